// File: rtl/gci_std_display_vram_if_responder.sv
// Memory-side responder for the display VRAM read interface.
// Grants one REQ/ACK/FINISH read session at a time, queues read addresses,
// issues them in order to a single-port VRAM port and returns the data
// to the reader in order with a fixed one-cycle latency.
module gci_std_display_vram_if_responder #(
  parameter int unsigned P_MEM_ADDR_N    = 19,
  parameter int unsigned P_QUEUE_DEPTH   = 8,
  parameter int unsigned P_QUEUE_DEPTH_N = 3
) (
  input  logic                    iGCI_CLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iIF_REQ,
  output logic                    oIF_ACK,
  input  logic                    iIF_FINISH,
  input  logic                    iIF_ENA,
  output logic                    oIF_BUSY,
  input  logic [P_MEM_ADDR_N-1:0] iIF_ADDR,
  output logic                    oIF_VALID,
  output logic [31:0]             oIF_DATA,
  output logic                    oMEM_REQ,
  input  logic                    iMEM_BUSY,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  input  logic                    iMEM_VALID,
  input  logic [31:0]             iMEM_DATA,
  output logic                    oPROTO_ERR
);

  localparam int unsigned CW = P_QUEUE_DEPTH_N + 1;
  // One extra bit: repeated flushes can leave returns from more than one
  // session still owed by the memory.
  localparam int unsigned DW = P_QUEUE_DEPTH_N + 2;
  localparam logic [CW-1:0] FULL = CW'(P_QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_SESSION,
    ST_DRAIN
  } state_t;

  state_t                      state_q, state_d;
  logic [P_QUEUE_DEPTH_N-1:0]  wr_ptr_q, wr_ptr_d;
  logic [P_QUEUE_DEPTH_N-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               pending_q, pending_d;
  logic [DW-1:0]               discard_q, discard_d;
  logic                        ack_q, ack_d;
  logic                        if_valid_q, if_valid_d;
  logic [31:0]                 if_data_q, if_data_d;
  logic                        err_q, err_d;
  logic [P_MEM_ADDR_N-1:0]     queue_q [P_QUEUE_DEPTH];

  logic                        busy;
  logic                        accept;
  logic                        push;
  logic                        issue;
  logic                        discard_hit;
  logic                        ret;
  logic                        stray;
  logic                        consume;
  logic [CW-1:0]               inflight;

  assign busy        = (state_q != ST_SESSION) || (pending_q == FULL);
  assign accept      = iIF_ENA && !busy;
  assign push        = accept && !iRESET_SYNC;
  assign issue       = (count_q != '0) && !iMEM_BUSY;
  assign discard_hit = iMEM_VALID && (discard_q != '0);
  assign ret         = iMEM_VALID && (discard_q == '0) && (pending_q != '0);
  assign stray       = iMEM_VALID && (discard_q == '0) && (pending_q == '0);
  assign inflight    = pending_q - count_q;
  assign consume     = iMEM_VALID && ((discard_q != '0) || (inflight != '0));

  assign oIF_ACK    = ack_q;
  assign oIF_BUSY   = busy;
  assign oIF_VALID  = if_valid_q;
  assign oIF_DATA   = if_data_q;
  assign oMEM_REQ   = (count_q != '0);
  assign oMEM_ADDR  = queue_q[rd_ptr_q];
  assign oPROTO_ERR = err_q;

  // Next-state: session FSM, queue pointers, pending/discard counters, return path.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    if_valid_d = ret;
    if_data_d  = ret ? iMEM_DATA : if_data_q;
    err_d      = err_q
               | (iIF_ENA    && (state_q != ST_SESSION))
               | (iIF_FINISH && (state_q != ST_SESSION))
               | stray;

    unique case (state_q)
      ST_IDLE:    if (iIF_REQ) state_d = ST_ACK;
      ST_ACK:     state_d = ST_SESSION;
      ST_SESSION: if (iIF_FINISH) state_d = ST_DRAIN;
      ST_DRAIN:   if (pending_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !issue)      count_d = count_q + CW'(1);
    else if (!push && issue) count_d = count_q - CW'(1);

    if (accept && !ret)      pending_d = pending_q + CW'(1);
    else if (!accept && ret) pending_d = pending_q - CW'(1);

    if (discard_hit) discard_d = discard_q - DW'(1);

    if (iRESET_SYNC) begin
      // Everything issued but not yet returned, including a command the
      // memory takes on this very edge, is owed back and must be swallowed.
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pending_d  = '0;
      discard_d  = discard_q + DW'(inflight) + DW'(issue) - DW'(consume);
      if_valid_d = 1'b0;
      err_d      = 1'b0;
    end

    ack_d = (state_d == ST_ACK);
  end

  // State and queue storage registers.
  always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      discard_q  <= '0;
      ack_q      <= 1'b0;
      if_valid_q <= 1'b0;
      if_data_q  <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < P_QUEUE_DEPTH; i++) queue_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      ack_q      <= ack_d;
      if_valid_q <= if_valid_d;
      if_data_q  <= if_data_d;
      err_q      <= err_d;
      if (push) queue_q[wr_ptr_q] <= iIF_ADDR;
    end
  end

endmodule

// File: tb/tb_gci_std_display_vram_if_responder.sv
// Self-checking bench for gci_std_display_vram_if_responder.
// Inputs are driven and outputs sampled on the falling clock edge. Accepted
// addresses go to a scoreboard queue, issued ones to a latency-3 memory
// model; every return is expected on oIF_VALID exactly one cycle later.
module tb_gci_std_display_vram_if_responder;

  localparam int AW  = 19;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rst_sync;
  logic          req;
  logic          ack;
  logic          finish;
  logic          ena;
  logic          busy;
  logic [AW-1:0] addr;
  logic          valid;
  logic [31:0]   data;
  logic          mreq;
  logic          mbusy;
  logic [AW-1:0] maddr;
  logic          mvalid;
  logic [31:0]   mdata;
  logic          perr;

  always #5 clk = ~clk;

  gci_std_display_vram_if_responder #(
    .P_MEM_ADDR_N   (AW),
    .P_QUEUE_DEPTH  (8),
    .P_QUEUE_DEPTH_N(3)
  ) dut (
    .iGCI_CLOCK (clk),
    .inRESET    (rst_n),
    .iRESET_SYNC(rst_sync),
    .iIF_REQ    (req),
    .oIF_ACK    (ack),
    .iIF_FINISH (finish),
    .iIF_ENA    (ena),
    .oIF_BUSY   (busy),
    .iIF_ADDR   (addr),
    .oIF_VALID  (valid),
    .oIF_DATA   (data),
    .oMEM_REQ   (mreq),
    .iMEM_BUSY  (mbusy),
    .oMEM_ADDR  (maddr),
    .iMEM_VALID (mvalid),
    .iMEM_DATA  (mdata),
    .oPROTO_ERR (perr)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } inflight_t;

  logic [AW-1:0] exp_addr[$];
  inflight_t     model_q[$];
  int            cyc;
  int            n_assert;
  int            n_fail;
  int            exp_discard;
  int            n_returns;
  bit            mem_hold;
  bit            stray_pulse;
  bit            ret_this_step;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {13'h0A5A, a};
  endfunction

  // One clock cycle: drive memory return, track issues, check return path.
  task automatic step();
    logic          pushed;
    logic [31:0]   exp_word;
    inflight_t     r;
    logic [AW-1:0] a;
    pushed   = 1'b0;
    exp_word = '0;
    mvalid   = 1'b0;
    if (stray_pulse) begin
      mvalid      = 1'b1;
      mdata       = 32'hDEAD_BEEF;
      stray_pulse = 1'b0;
    end else if (!mem_hold && model_q.size() > 0 && model_q[0].due <= cyc) begin
      r      = model_q.pop_front();
      mvalid = 1'b1;
      mdata  = mem_word(r.addr);
      if (exp_discard > 0) exp_discard--;
      else begin
        pushed   = 1'b1;
        exp_word = mem_word(r.addr);
      end
    end
    if (mreq) begin
      n_assert++;
      if (exp_addr.size() == 0) begin
        n_fail++;
        $display("FAIL mem_req_unexpected: oMEM_REQ=1 oMEM_ADDR=%h, required no request", maddr);
      end else begin
        if (maddr !== exp_addr[0]) begin
          n_fail++;
          $display("FAIL mem_addr: got %h, required %h", maddr, exp_addr[0]);
        end
        if (!mbusy) begin
          a      = exp_addr.pop_front();
          r.addr = a;
          r.due  = cyc + LAT;
          model_q.push_back(r);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ret_this_step = valid;
    n_assert++;
    if (valid !== pushed) begin
      n_fail++;
      $display("FAIL if_valid: got %b, required %b (cycle %0d)", valid, pushed, cyc);
    end else if (pushed) begin
      n_assert++;
      n_returns++;
      if (data !== exp_word) begin
        n_fail++;
        $display("FAIL if_data: got %h, required %h", data, exp_word);
      end
    end
  endtask

  task automatic wait_quiet(input int budget);
    int i;
    i = 0;
    while ((exp_addr.size() != 0 || model_q.size() != 0) && i < budget) begin
      step();
      i++;
    end
    n_assert++;
    if (exp_addr.size() != 0 || model_q.size() != 0) begin
      n_fail++;
      $display("FAIL quiet_timeout: %0d queued and %0d in flight remain, required 0", exp_addr.size(), model_q.size());
    end
  endtask

  task automatic test_reset();
    n_assert++;
    if ({ack, valid, data, perr, mreq, busy} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b valid=%b data=%h err=%b mreq=%b busy=%b, required 0 0 0 0 0 1", ack, valid, data, perr, mreq, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_session();
    int rets0;
    req = 1'b1;
    step();
    n_assert++;
    if (ack !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ack: ack=%b busy=%b, required ack=1 busy=1", ack, busy);
    end
    req = 1'b0;
    step();
    n_assert++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_session: ack=%b busy=%b, required ack=0 busy=0", ack, busy);
    end
    rets0 = n_returns;
    ena  = 1'b1;
    addr = 19'h00010;
    exp_addr.push_back(19'h00010);
    step();
    ena = 1'b0;
    n_assert++;
    if (mreq !== 1'b1 || maddr !== 19'h00010) begin
      n_fail++;
      $display("FAIL basic_mem_req: mreq=%b addr=%h, required 1 00010", mreq, maddr);
    end
    wait_quiet(20);
    n_assert++;
    if (n_returns - rets0 != 1) begin
      n_fail++;
      $display("FAIL basic_returns: got %0d, required 1", n_returns - rets0);
    end
    step();
    n_assert++;
    if (data !== mem_word(19'h00010)) begin
      n_fail++;
      $display("FAIL data_hold: got %h, required %h", data, mem_word(19'h00010));
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int i;
    mbusy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_assert++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_busy_early: got %b at command %0d, required 0", busy, k);
      end
      ena  = 1'b1;
      addr = AW'(19'h00100 + k * 3);
      exp_addr.push_back(AW'(19'h00100 + k * 3));
      step();
    end
    ena = 1'b0;
    n_assert++;
    if (busy !== 1'b1 || maddr !== 19'h00100) begin
      n_fail++;
      $display("FAIL bp_full: busy=%b addr=%h, required 1 00100", busy, maddr);
    end
    step();
    step();
    mbusy = 1'b0;
    seen  = 1'b0;
    i     = 0;
    while ((exp_addr.size() != 0 || model_q.size() != 0) && i < 40) begin
      step();
      i++;
      if (!seen) begin
        n_assert++;
        if (busy !== ret_this_step ? 1'b0 : 1'b1) begin
          n_fail++;
          $display("FAIL bp_release: busy=%b ret=%b, required busy=%b", busy, ret_this_step, !ret_this_step);
        end
        seen = ret_this_step;
      end
    end
    wait_quiet(10);
  endtask

  task automatic test_simultaneous();
    mem_hold = 1'b1;
    mbusy    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ena  = 1'b1;
      addr = AW'(19'h02000 + k);
      exp_addr.push_back(AW'(19'h02000 + k));
      step();
    end
    ena = 1'b0;
    for (int k = 0; k < 10 && exp_addr.size() != 0; k++) step();
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_full_busy: got %b, required 1", busy);
    end
    ena      = 1'b1;
    addr     = 19'h7FFFF;
    mem_hold = 1'b0;
    step();
    ena = 1'b0;
    n_assert++;
    if (dut.pending_q !== 4'd7) begin
      n_fail++;
      $display("FAIL sim_full_pending: got %0d, required 7", dut.pending_q);
    end
    step();
    step();
    mem_hold = 1'b1;
    n_assert++;
    if (dut.pending_q !== 4'd5) begin
      n_fail++;
      $display("FAIL sim_pending5_pre: got %0d, required 5", dut.pending_q);
    end
    ena  = 1'b1;
    addr = 19'h55555;
    exp_addr.push_back(19'h55555);
    mem_hold = 1'b0;
    step();
    ena = 1'b0;
    n_assert++;
    if (dut.pending_q !== 4'd5 || ret_this_step !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_pending5: pending=%0d ret=%b, required 5 1", dut.pending_q, ret_this_step);
    end
    wait_quiet(40);
  endtask

  task automatic test_drain();
    int rets;
    mem_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ena  = 1'b1;
      addr = AW'(19'h30000 + k);
      exp_addr.push_back(AW'(19'h30000 + k));
      step();
    end
    ena = 1'b0;
    for (int k = 0; k < 10 && exp_addr.size() != 0; k++) step();
    finish = 1'b1;
    req    = 1'b1;
    step();
    finish = 1'b0;
    n_assert++;
    if (busy !== 1'b1 || perr !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_enter: busy=%b err=%b, required 1 0", busy, perr);
    end
    mem_hold = 1'b0;
    rets     = 0;
    for (int k = 0; k < 30 && rets < 3; k++) begin
      step();
      if (ret_this_step) rets++;
      n_assert++;
      if (ack !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_ack_early: got %b, required 0", ack);
      end
    end
    n_assert++;
    if (rets != 3) begin
      n_fail++;
      $display("FAIL drain_returns: got %0d, required 3", rets);
    end
    step();
    n_assert++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle_ack: got %b, required 0", ack);
    end
    step();
    n_assert++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_reack: got %b, required 1", ack);
    end
    req = 1'b0;
    step();
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_new_session: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_flush();
    mem_hold = 1'b1;
    mbusy    = 1'b0;
    ena = 1'b1; addr = 19'h40000; exp_addr.push_back(19'h40000); step();
    ena = 1'b1; addr = 19'h40001; exp_addr.push_back(19'h40001); step();
    ena = 1'b0; step();
    mbusy = 1'b1;
    for (int k = 2; k < 5; k++) begin
      ena  = 1'b1;
      addr = AW'(19'h40000 + k);
      exp_addr.push_back(AW'(19'h40000 + k));
      step();
    end
    ena = 1'b0;
    n_assert++;
    if (dut.pending_q !== 4'd5 || model_q.size() != 2) begin
      n_fail++;
      $display("FAIL flush_setup: pending=%0d issued=%0d, required 5 2", dut.pending_q, model_q.size());
    end
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    exp_addr.delete();
    exp_discard = model_q.size();
    n_assert++;
    if (mreq !== 1'b0 || busy !== 1'b1 || dut.pending_q !== 4'd0 || dut.discard_q !== 5'd2 || perr !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: mreq=%b busy=%b pending=%0d discard=%0d err=%b, required 0 1 0 2 0", mreq, busy, dut.pending_q, dut.discard_q, perr);
    end
    mbusy    = 1'b0;
    mem_hold = 1'b0;
    wait_quiet(20);
    n_assert++;
    if (perr !== 1'b0 || dut.discard_q !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_discard: err=%b discard=%0d, required 0 0", perr, dut.discard_q);
    end
  endtask

  task automatic test_errors();
    ena  = 1'b1;
    addr = 19'h11111;
    step();
    ena = 1'b0;
    n_assert++;
    if (perr !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ena_idle: got %b, required 1", perr);
    end
    step();
    n_assert++;
    if (perr !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", perr);
    end
    rst_sync = 1'b1; step(); rst_sync = 1'b0;
    n_assert++;
    if (perr !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b, required 0", perr);
    end
    stray_pulse = 1'b1;
    step();
    n_assert++;
    if (perr !== 1'b1) begin
      n_fail++;
      $display("FAIL err_stray_valid: got %b, required 1", perr);
    end
    rst_sync = 1'b1; step(); rst_sync = 1'b0;
    finish = 1'b1;
    step();
    finish = 1'b0;
    n_assert++;
    if (perr !== 1'b1) begin
      n_fail++;
      $display("FAIL err_finish_idle: got %b, required 1", perr);
    end
    rst_sync = 1'b1; step(); rst_sync = 1'b0;
  endtask

  task automatic test_async_reset();
    req = 1'b1; step();
    req = 1'b0; step();
    stray_pulse = 1'b1;
    step();
    mbusy = 1'b1;
    ena   = 1'b1;
    addr  = 19'h12345;
    exp_addr.push_back(19'h12345);
    step();
    ena = 1'b0;
    step();
    n_assert++;
    if (mreq !== 1'b1 || perr !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_setup: mreq=%b err=%b busy=%b, required 1 1 0", mreq, perr, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({ack, valid, data, perr, mreq, busy} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_outputs: ack=%b valid=%b data=%h err=%b mreq=%b busy=%b, required 0 0 0 0 0 1", ack, valid, data, perr, mreq, busy);
    end
    exp_addr.delete();
    model_q.delete();
    exp_discard = 0;
    mbusy       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst_sync = 1'b0; req = 1'b0; finish = 1'b0; ena = 1'b0;
    addr = '0; mbusy = 1'b0; mvalid = 1'b0; mdata = '0;
    cyc = 0; n_assert = 0; n_fail = 0; exp_discard = 0; n_returns = 0;
    mem_hold = 1'b0; stray_pulse = 1'b0; ret_this_step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic_session();
    test_backpressure();
    test_simultaneous();
    test_drain();
    test_flush();
    test_errors();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
